// File: rtl/ghash_pkg.sv
// ghash_pkg: shared types and constants for the GF(2^128) GHASH multiplier.
//   gf128_t        128-bit field element, GCM bit order (bit 127 = x^0).
//   GF_R           reduction constant for x^128+x^7+x^2+x+1 in reflected order.
//   ghash_state_e  GHASH-mode controller states.
//   gf128_mul_ref  plain bit-serial product, used as a reference model.
package ghash_pkg;

  typedef logic [127:0] gf128_t;

  localparam gf128_t GF_R = {8'he1, 120'h0};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_OUT
  } ghash_state_e;

  function automatic gf128_t gf128_mul_ref(input gf128_t x, input gf128_t h);
    gf128_t z;
    gf128_t v;
    z = '0;
    v = x;
    for (int i = 127; i >= 0; i--) begin
      if (h[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

endpackage

// File: rtl/ghash_mul_slice.sv
// ghash_mul_slice: combinational slice of the bit-serial GF(2^128) multiply.
// Consumes SPLIT_WIDTH bits of H, MSB first, advancing the (V, Z) pair.
//   h_slice  H bits handled by this slice (bit SPLIT_WIDTH-1 processed first)
//   v_in     running multiplicand V
//   z_in     partial product Z
//   v_out    V after SPLIT_WIDTH shift/reduce steps
//   z_out    Z after SPLIT_WIDTH conditional accumulations
module ghash_mul_slice
  import ghash_pkg::*;
#(
  parameter int SPLIT_WIDTH = 32
) (
  input  logic [SPLIT_WIDTH-1:0] h_slice,
  input  gf128_t                 v_in,
  input  gf128_t                 z_in,
  output gf128_t                 v_out,
  output gf128_t                 z_out
);

  gf128_t v;
  gf128_t z;

  always_comb begin
    v = v_in;
    z = z_in;
    for (int i = SPLIT_WIDTH - 1; i >= 0; i--) begin
      if (h_slice[i]) z = z ^ v;
      // Right shift is multiplication by x in reflected order; reduce on carry-out.
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
  end

  assign v_out = v;
  assign z_out = z;

endmodule

// File: rtl/ghash_pipe_mul.sv
// ghash_pipe_mul: pipelined GF(2^128) multiplier X*H with a GHASH chaining mode.
// H is split across NUM_STAGES slices; an extra input register makes the
// accept-to-out_valid latency exactly NUM_STAGES cycles.
//   clk, rst         clock, synchronous active-low reset
//   h_load, h_i      load the hash subkey H
//   mode_i           0 = independent products, 1 = GHASH chain (first beat)
//   in_valid/ready   input handshake; in_data = X, in_last ends a GHASH message
//   out_valid/ready  output handshake; out_data = product or final Y
module ghash_pipe_mul
  import ghash_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_load,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic                  mode_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int SPLIT_WIDTH = DATA_WIDTH / NUM_STAGES;
  localparam int CNT_W       = $clog2(NUM_STAGES + 1);

  gf128_t                h_q;
  gf128_t                y_q;
  gf128_t                v_p [NUM_STAGES];
  gf128_t                z_p [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_p;
  logic [NUM_STAGES-1:0] emit_p;
  gf128_t                v_s [NUM_STAGES];
  gf128_t                z_s [NUM_STAGES];

  ghash_state_e          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last_q;
  logic                  msg_open_q;
  logic                  ready_en_q;

  logic                  stall;
  logic                  accept;
  logic                  eff_ghash;
  logic                  pipe_busy;
  logic                  emit_in;
  gf128_t                operand;

  assign stall     = out_valid & ~out_ready;
  assign pipe_busy = (|vld_p) | out_valid;
  // An open GHASH message pins the mode until its result is consumed.
  assign eff_ghash = msg_open_q | mode_i;
  assign emit_in   = eff_ghash ? in_last : 1'b1;
  assign operand   = msg_open_q ? (y_q ^ in_data) : in_data;
  assign accept    = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (rst && ready_en_q && state_q == IDLE) begin
      // GHASH beats need an empty pipe (also drains MUL traffic on a mode switch).
      in_ready = eff_ghash ? ~pipe_busy : ~stall;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    ghash_mul_slice #(
      .SPLIT_WIDTH(SPLIT_WIDTH)
    ) u_slice (
      .h_slice(h_q[DATA_WIDTH-1-k*SPLIT_WIDTH -: SPLIT_WIDTH]),
      .v_in   (v_p[k]),
      .z_in   (z_p[k]),
      .v_out  (v_s[k]),
      .z_out  (z_s[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        v_p[k] <= '0;
        z_p[k] <= '0;
      end
      vld_p     <= '0;
      emit_p    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      // p0: operand capture (V = X or Y^X, Z = 0)
      vld_p[0]  <= accept;
      emit_p[0] <= emit_in;
      if (accept) begin
        v_p[0] <= operand;
        z_p[0] <= '0;
      end
      // p1..pN-1: slice k-1 results feed slice k
      for (int k = 1; k < NUM_STAGES; k++) begin
        vld_p[k]  <= vld_p[k-1];
        emit_p[k] <= emit_p[k-1];
        if (vld_p[k-1]) begin
          v_p[k] <= v_s[k-1];
          z_p[k] <= z_s[k-1];
        end
      end
      // output register: intermediate GHASH blocks are not emitted
      out_valid <= vld_p[NUM_STAGES-1] & emit_p[NUM_STAGES-1];
      if (vld_p[NUM_STAGES-1]) out_data <= z_s[NUM_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      msg_open_q <= 1'b0;
      ready_en_q <= 1'b0;
      y_q        <= '0;
      h_q        <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (h_load) h_q <= h_i;
      case (state_q)
        IDLE: begin
          if (accept && eff_ghash) begin
            state_q    <= BUSY;
            cnt_q      <= CNT_W'(NUM_STAGES);
            last_q     <= in_last;
            msg_open_q <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          // Count of one means the block is leaving the last slice this cycle.
          if (cnt_q == CNT_W'(1)) begin
            y_q     <= z_s[NUM_STAGES-1];
            state_q <= last_q ? WAIT_OUT : IDLE;
          end
        end
        WAIT_OUT: begin
          if (out_valid && out_ready) begin
            y_q        <= '0;
            msg_open_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_h_load_idle : assert property (@(posedge clk) disable iff (!rst) h_load |-> !pipe_busy);

endmodule

// File: tb/tb_ghash_pipe_mul.sv
module tb_ghash_pipe_mul;
  import ghash_pkg::*;

  localparam int     NS     = 4;
  localparam gf128_t X_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam gf128_t H_TC2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam gf128_t XH_TC2 = 128'h5e2ec746917062882c85b0685353deb7;
  localparam gf128_t LEN_B  = 128'h00000000000000000000000000000080;
  localparam gf128_t TAG_B  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam gf128_t H_ONE  = 128'h80000000000000000000000000000000;
  localparam int     SW_NS [4] = '{1, 2, 8, 16};

  logic   clk = 1'b0;
  logic   rst, h_load, mode_i, in_valid, in_last, out_ready;
  logic   in_ready, out_valid;
  gf128_t h_i, in_data, out_data;

  logic   sw_h_load, sw_valid;
  gf128_t sw_h, sw_data;

  int     checks   = 0;
  int     failures = 0;
  int     n_out    = 0;
  int     cyc_cnt  = 0;
  gf128_t exp_q[$];
  logic   stalled_prev = 1'b0;
  gf128_t data_prev;
  logic   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  ghash_pipe_mul #(.DATA_WIDTH(128), .NUM_STAGES(NS)) u_dut (
    .clk(clk), .rst(rst), .h_load(h_load), .h_i(h_i), .mode_i(mode_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic check(input string tag, input gf128_t obs, input gf128_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; waited = cycles spent with in_ready low.
  task automatic send(input gf128_t x, input logic mode, input logic last, output int waited);
    in_valid = 1'b1; in_data = x; mode_i = mode; in_last = last; waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check_bit("send_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check_bit("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic load_h(input gf128_t h);
    h_i = h; h_load = 1'b1;
    tick();
    h_load = 1'b0;
  endtask

  // Main DUT scoreboard and AXI-style hold checks
  always @(negedge clk) begin
    if (!rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check_bit("stall_valid_hold", out_valid, 1'b1);
        check("stall_data_hold", out_data, data_prev);
      end
      if (out_valid && !out_ready) check_bit("stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        check_bit("sb_output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
        n_out++;
      end
      stalled_prev = out_valid && !out_ready;
      data_prev    = out_data;
    end
  end

  // Depth sweep: independent instances fed one shared MUL stream
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int N = SW_NS[g];
    logic   rdy, ov;
    gf128_t od;
    gf128_t eq[$];
    int     tq[$];
    int     n_seen = 0;

    ghash_pipe_mul #(.DATA_WIDTH(128), .NUM_STAGES(N)) u_dut (
      .clk(clk), .rst(rst), .h_load(sw_h_load), .h_i(sw_h), .mode_i(1'b0),
      .in_valid(sw_valid), .in_ready(rdy), .in_data(sw_data), .in_last(1'b0),
      .out_valid(ov), .out_ready(1'b1), .out_data(od)
    );

    always @(posedge clk) begin
      if (rst && sw_valid && rdy) begin
        eq.push_back(gf128_mul_ref(sw_data, sw_h));
        tq.push_back(cyc_cnt + 1);
      end
    end

    always @(negedge clk) begin
      if (rst && ov) begin
        check_bit("sweep_output_expected", eq.size() != 0, 1'b1);
        if (eq.size() != 0) begin
          check("sweep_data", od, eq.pop_front());
          check_int("sweep_latency", cyc_cnt - tq.pop_front(), N);
        end
        n_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     w, lat, i, cyc;
    gf128_t xs [8];

    rst = 1'b0; h_load = 1'b0; h_i = '0; mode_i = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    sw_h_load = 1'b0; sw_valid = 1'b0; sw_h = '0; sw_data = '0;

    // Reset state
    repeat (3) tick();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, '0);
    rst = 1'b1;
    tick();
    check_bit("post_rst_in_ready", in_ready, 1'b1);
    check_bit("post_rst_out_valid", out_valid, 1'b0);

    // Identity multiply
    load_h(H_ONE);
    exp_q.push_back(X_TC2);
    send(X_TC2, 1'b0, 1'b0, w);
    check_int("id_accept_wait", w, 0);
    wait_out(lat);
    check_int("id_latency", lat, NS);
    repeat (2) tick();

    // NIST product
    load_h(H_TC2);
    exp_q.push_back(XH_TC2);
    send(X_TC2, 1'b0, 1'b0, w);
    wait_out(lat);
    check_int("nist_latency", lat, NS);
    repeat (2) tick();

    // GHASH two-block message; mode_i low on the second beat must be ignored
    send(X_TC2, 1'b1, 1'b0, w);
    check_int("gh_first_wait", w, 0);
    exp_q.push_back(TAG_B);
    send(LEN_B, 1'b0, 1'b1, w);
    check_int("gh_block_gap", w, NS);
    wait_out(lat);
    check_int("gh_latency", lat, NS);
    repeat (2) tick();
    check_bit("gh_sb_empty", exp_q.size() == 0, 1'b1);
    check_int("gh_out_count", n_out, 3);

    // Backpressure with out_ready pattern 1,0,0,1
    for (int k = 0; k < 8; k++) xs[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    n_out = 0; i = 0; cyc = 0;
    while ((i < 8 || exp_q.size() != 0) && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (i < 8);
      in_data   = (i < 8) ? xs[i] : '0;
      mode_i    = 1'b0;
      in_last   = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(gf128_mul_ref(xs[i], H_TC2));
        i++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_bit("bp_drained", exp_q.size() == 0, 1'b1);
    check_int("bp_out_count", n_out, 8);
    check_int("bp_accepted", i, 8);
    repeat (2) tick();

    // Reset in the middle of a GHASH message
    send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, w);
    send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, w);
    tick();
    rst = 1'b0;
    tick();
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_bit("midrst_release_ready", in_ready, 1'b1);
    load_h(H_TC2);
    exp_q.push_back('0);
    send('0, 1'b1, 1'b1, w);
    check_int("midrst_fresh_wait", w, 0);
    wait_out(lat);
    check_int("midrst_latency", lat, NS);
    repeat (2) tick();
    check_bit("midrst_sb_empty", exp_q.size() == 0, 1'b1);

    // Depth sweep, 1000 random products per depth
    sw_h = {$urandom(), $urandom(), $urandom(), $urandom()};
    sw_h_load = 1'b1;
    tick();
    sw_h_load = 1'b0;
    tick();
    for (int k = 0; k < 1000; k++) begin
      sw_valid = 1'b1;
      sw_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    sw_valid = 1'b0;
    repeat (24) tick();
    check_int("sweep_count_ns1", g_sw[0].n_seen, 1000);
    check_int("sweep_count_ns2", g_sw[1].n_seen, 1000);
    check_int("sweep_count_ns8", g_sw[2].n_seen, 1000);
    check_int("sweep_count_ns16", g_sw[3].n_seen, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
